// File: rtl/ping_sampler.sv
// Scheduler and post-processor for the ultrasonic ping core: periodic req/done handshake,
// timeout rejection, power-of-two moving average and near flag. PING_SAMPLER_MEDIAN3_EN adds a 3-tap median stage.
module ping_sampler #(
  parameter int unsigned HOLDOFF_CYCLES = 1200000,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned NEAR_CM        = 30,
  parameter int unsigned HYST_CM        = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        err_clr,
  output logic        ping_req,
  input  logic        ping_done,
  input  logic [7:0]  ping_distance,
  output logic        busy,
  output logic [7:0]  raw_dist,
  output logic        raw_valid,
  output logic        raw_err,
  output logic [7:0]  avg_dist,
  output logic        avg_valid,
  output logic        near,
  output logic [15:0] err_cnt
);
  localparam int unsigned WIN = 1 << AVG_LOG2;
  localparam int unsigned SW  = 8 + AVG_LOG2;
  localparam int unsigned PW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned CW  = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_cap, w_to, w_win_clr;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_REQ;
      S_REQ:   if (!enable) w_state_nxt = S_IDLE;
               else if (ping_done) w_state_nxt = S_HOLD;
      S_HOLD:  if (!enable) w_state_nxt = S_IDLE;
               else if (r_cnt == CW'(HOLDOFF_CYCLES - 1)) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ping_req = (r_state == S_REQ);
    busy     = (r_state != S_IDLE);
  end

  // Counter idles at zero outside HOLD, so it is already cleared on entry.
  always_ff @(posedge clk) begin
    if (!resetn || r_state != S_HOLD) r_cnt <= '0;
    else                              r_cnt <= r_cnt + CW'(1);
  end

  assign w_cap     = (r_state == S_REQ) && enable && ping_done;
  assign w_to      = (ping_distance == 8'hFF);
  assign w_win_clr = (r_state != S_IDLE) && !enable;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      raw_dist  <= '0;
      raw_valid <= 1'b0;
      raw_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      raw_valid <= w_cap;
      if (w_cap) begin
        raw_dist <= ping_distance;
        raw_err  <= w_to;
      end
      if (err_clr)                                   err_cnt <= '0;
      else if (w_cap && w_to && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  logic [7:0] w_smp;
  logic       w_smp_vld;

`ifdef PING_SAMPLER_MEDIAN3_EN
  logic [7:0] r_h0, r_h1, r_med;
  logic       r_med_vld, r_med_empty, w_raw_ok;

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  assign w_raw_ok = raw_valid && !raw_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_h0        <= '0;
      r_h1        <= '0;
      r_med       <= '0;
      r_med_vld   <= 1'b0;
      r_med_empty <= 1'b1;
    end else begin
      r_med_vld <= w_raw_ok;
      if (w_raw_ok) begin
        if (r_med_empty) begin
          r_h0  <= raw_dist;
          r_h1  <= raw_dist;
          r_med <= raw_dist;
        end else begin
          r_h1  <= r_h0;
          r_h0  <= raw_dist;
          r_med <= med3(r_h1, r_h0, raw_dist);
        end
      end
      if (w_win_clr)     r_med_empty <= 1'b1;
      else if (w_raw_ok) r_med_empty <= 1'b0;
    end
  end

  assign w_smp     = r_med;
  assign w_smp_vld = r_med_vld;
`else
  assign w_smp     = raw_dist;
  assign w_smp_vld = raw_valid && !raw_err;
`endif

  logic [WIN-1:0][7:0] r_buf;
  logic [SW-1:0]       r_sum, w_sum_nxt;
  logic [PW-1:0]       r_ptr;
  logic                r_empty;
  logic [7:0]          w_avg_nxt;

  always_comb begin
    if (r_empty) w_sum_nxt = SW'(w_smp) << AVG_LOG2;
    else         w_sum_nxt = r_sum - SW'(r_buf[r_ptr]) + SW'(w_smp);
    w_avg_nxt = w_sum_nxt[SW-1:AVG_LOG2];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_buf     <= '0;
      r_sum     <= '0;
      r_ptr     <= '0;
      r_empty   <= 1'b1;
      avg_dist  <= '0;
      avg_valid <= 1'b0;
      near      <= 1'b0;
    end else begin
      avg_valid <= w_smp_vld;
      if (w_smp_vld) begin
        // An empty window is pre-filled so the first average equals the first sample.
        if (r_empty) r_buf <= {WIN{w_smp}};
        else begin
          r_buf[r_ptr] <= w_smp;
          r_ptr        <= (r_ptr == PW'(WIN - 1)) ? '0 : r_ptr + PW'(1);
        end
        r_sum    <= w_sum_nxt;
        avg_dist <= w_avg_nxt;
        if (w_avg_nxt < 8'(NEAR_CM))                 near <= 1'b1;
        else if (w_avg_nxt >= 8'(NEAR_CM + HYST_CM)) near <= 1'b0;
      end
      if (w_win_clr)      r_empty <= 1'b1;
      else if (w_smp_vld) r_empty <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ping_sampler.sv
// Self-checking bench for ping_sampler: directed table, handshake/disable sequences and
// randomized pings against a list-based reference model (median-aware under PING_SAMPLER_MEDIAN3_EN).
module tb_ping_sampler;
  localparam int HOLD = 100;
  localparam int ALOG = 2;
  localparam int WIN  = 1 << ALOG;
  localparam int NEAR = 30;
  localparam int HYST = 5;
`ifdef PING_SAMPLER_MEDIAN3_EN
  localparam int LAT = 3;
  localparam bit MED = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit MED = 1'b0;
`endif

  logic        clk = 1'b0, resetn, enable, err_clr, ping_done;
  logic [7:0]  ping_distance;
  logic        ping_req, busy, raw_valid, raw_err, avg_valid, near;
  logic [7:0]  raw_dist, avg_dist;
  logic [15:0] err_cnt;

  ping_sampler #(.HOLDOFF_CYCLES(HOLD), .AVG_LOG2(ALOG), .NEAR_CM(NEAR), .HYST_CM(HYST)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .err_clr(err_clr),
    .ping_req(ping_req), .ping_done(ping_done), .ping_distance(ping_distance),
    .busy(busy), .raw_dist(raw_dist), .raw_valid(raw_valid), .raw_err(raw_err),
    .avg_dist(avg_dist), .avg_valid(avg_valid), .near(near), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int t_cap = 0;

  // Reference model state: sample lists since the window was last emptied.
  int s_q[$];
  int a_q[$];
  int m_avg = 0, m_err = 0;
  bit m_near = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int median_of(input int a, input int b, input int c);
    int t[$];
    t = '{a, b, c};
    t.sort();
    return t[1];
  endfunction

  function automatic void model_clear();
    s_q.delete();
    a_q.delete();
  endfunction

  function automatic void model_push(input int x);
    int n, m, sum, idx;
    s_q.push_back(x);
    n = s_q.size();
    if (MED) m = median_of((n >= 3) ? s_q[n-3] : s_q[0], (n >= 2) ? s_q[n-2] : s_q[0], x);
    else     m = x;
    a_q.push_back(m);
    sum = 0;
    for (int i = 0; i < WIN; i++) begin
      idx = a_q.size() - 1 - i;
      sum += (idx >= 0) ? a_q[idx] : a_q[0];
    end
    m_avg = sum / WIN;
    if (m_avg < NEAR)             m_near = 1'b1;
    else if (m_avg >= NEAR + HYST) m_near = 1'b0;
  endfunction

  task automatic wait_req(input string nm, input int limit);
    int n = 0;
    while (ping_req !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(ping_req), 32'd1);
  endtask

  task automatic do_ping(input int d, input bit clr, input bit refill, input int dly, input bit gap_chk,
                         input bit use_tbl, input int t_avg, input bit t_near, input int t_err, input string tag);
    int ea, ee;
    bit en, tv;
    wait_req({tag, "_req"}, 3 * HOLD);
    if (gap_chk) chk({tag, "_gap"}, 32'(cyc - t_cap), 32'(HOLD));
    if (refill) begin
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      model_clear();
      wait_req({tag, "_rereq"}, 10);
    end
    repeat (dly) @(negedge clk);
    ping_done = 1'b1; ping_distance = 8'(d); err_clr = clr;
    @(negedge clk);
    ping_done = 1'b0; err_clr = 1'b0; ping_distance = 8'($urandom_range(0, 255));
    t_cap = cyc;
    tv = (d != 255);
    if (!tv && m_err < 65535) m_err++;
    if (clr) m_err = 0;
    if (tv) model_push(d);
    ea = use_tbl ? t_avg  : m_avg;
    en = use_tbl ? t_near : m_near;
    ee = use_tbl ? t_err  : m_err;
    chk({tag, "_reqlow"}, 32'(ping_req), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rvld"}, 32'(raw_valid), 32'd1);
    chk({tag, "_rdist"}, 32'(raw_dist), 32'(d));
    chk({tag, "_rerr"}, 32'(raw_err), 32'(!tv));
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'(ee));
    for (int k = 2; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 2) chk({tag, "_rvld_off"}, 32'(raw_valid), 32'd0);
      if (k < LAT) chk({tag, "_avld_early"}, 32'(avg_valid), 32'd0);
      else begin
        chk({tag, "_avld"}, 32'(avg_valid), 32'(tv));
        chk({tag, "_avg"}, 32'(avg_dist), 32'(ea));
        chk({tag, "_near"}, 32'(near), 32'(en));
      end
    end
  endtask

  typedef struct {
    int d; bit clr; bit refill; int dly; int avg; bit nr; int err;
  } vec_t;
  vec_t tbl[18];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{40,  0, 0, 10, 40,              0, 0};
    tbl[1]  = '{80,  0, 0, 1,  MED ? 40 : 50,   0, 0};
    tbl[2]  = '{80,  0, 0, 0,  MED ? 50 : 60,   0, 0};
    tbl[3]  = '{80,  0, 0, 3,  MED ? 60 : 70,   0, 0};
    tbl[4]  = '{80,  0, 0, 2,  MED ? 70 : 80,   0, 0};
    tbl[5]  = '{50,  0, 1, 1,  50,              0, 0};
    tbl[6]  = '{255, 0, 0, 1,  50,              0, 1};
    tbl[7]  = '{50,  0, 0, 4,  50,              0, 1};
    tbl[8]  = '{255, 1, 0, 0,  50,              0, 0};
    tbl[9]  = '{20,  0, 1, 2,  20,              1, 0};
    tbl[10] = '{32,  0, 1, 1,  32,              1, 0};
    tbl[11] = '{34,  0, 1, 0,  34,              1, 0};
    tbl[12] = '{35,  0, 1, 5,  35,              0, 0};
    tbl[13] = '{32,  0, 1, 1,  32,              0, 0};
    tbl[14] = '{29,  0, 1, 2,  29,              1, 0};
    tbl[15] = '{50,  0, 1, 1,  50,              0, 0};
    tbl[16] = '{200, 0, 0, 2,  MED ? 50 : 87,   0, 0};
    tbl[17] = '{50,  0, 0, 1,  MED ? 50 : 87,   0, 0};

    resetn = 1'b0; enable = 1'b1; err_clr = 1'b0; ping_done = 1'b0; ping_distance = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(ping_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvld", 32'(raw_valid), 32'd0);
    chk("rst_avld", 32'(avg_valid), 32'd0);
    chk("rst_near", 32'(near), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_dists", 32'({raw_dist, avg_dist}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("hs_req_rise", 32'(ping_req), 32'd1);

    for (int i = 0; i < 18; i++)
      do_ping(tbl[i].d, tbl[i].clr, tbl[i].refill, tbl[i].dly, i > 0, 1'b1,
              tbl[i].avg, tbl[i].nr, tbl[i].err, $sformatf("tbl%0d", i));

    // ping_done outside REQ must not capture.
    ping_done = 1'b1; ping_distance = 8'd77;
    @(negedge clk);
    ping_done = 1'b0;
    chk("hold_done_rvld", 32'(raw_valid), 32'd0);
    chk("hold_done_rdist", 32'(raw_dist), 32'd50);

    // Disable in REQ together with a done strobe: dropped, window emptied.
    wait_req("dis_req", 3 * HOLD);
    enable = 1'b0; ping_done = 1'b1; ping_distance = 8'd33;
    @(negedge clk);
    ping_done = 1'b0;
    chk("dis_reqlow", 32'(ping_req), 32'd0);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_rvld", 32'(raw_valid), 32'd0);
    enable = 1'b1;
    model_clear();
    do_ping(90, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 1'b0, 0, "dis90");
    chk("dis_avg90", 32'(avg_dist), 32'd90);

    for (int i = 0; i < 60; i++) begin
      int d;
      case ($urandom_range(0, 5))
        0:       d = 255;
        1, 2:    d = $urandom_range(20, 45);
        default: d = $urandom_range(0, 254);
      endcase
      do_ping(d, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 6),
              1'b1, 1'b0, 0, 1'b0, 0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
